// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch unit and its instruction queue.
package fetch_queue_pkg;

  localparam int unsigned IFQ_XLEN = 32;

  localparam logic [31:0] INSTR_NOP                = 32'h0000_0013;
  localparam logic [3:0]  EXC_CODE_INSTR_MISALIGN  = 4'd0;
  localparam logic [3:0]  EXC_CODE_INST_PAGE_FAULT = 4'd12;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } type_fetch_state_e;

  // One queued fetch result; the queue stores this packed layout.
  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic                exc_req;
    logic [3:0]          exc_code;
  } type_ifq_entry_s;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Parametrised synchronous FIFO with a flush input. The read port is
// combinational from the head slot. A push together with a pop is legal
// even when full: the head is read before the same slot is overwritten.
module fetch_queue_fifo #(
  parameter int unsigned W     = 69,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer and occupancy; flush empties the queue and wins over push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since count guards validity.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit with a QDEPTH-entry instruction queue between icache and ID.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty an icache
// response is forwarded to the ID outputs in the same cycle.
//
// Handshakes: icache_req_o stays high with a stable icache_addr_o until
// icache_ack_i; icache_ack_i is only meaningful while icache_req_o is high.
// The ID side pops the head on id_valid_o & id_ready_i.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_new_pc_req_i,
  input  logic              wfi_req_i,
  input  logic [XLEN-1:0]   csr_pc_new_i,
  input  logic              exe_new_pc_req_i,
  input  logic [XLEN-1:0]   exe_pc_new_i,
  input  logic              icache_flush_i,
  output logic              mmu_req_o,
  output logic [XLEN-1:0]   mmu_vaddr_o,
  input  logic              mmu_hit_i,
  input  logic [XLEN-1:0]   mmu_paddr_i,
  input  logic              mmu_page_fault_i,
  output logic              icache_req_o,
  output logic [XLEN-1:0]   icache_addr_o,
  output logic              icache_kill_o,
  output logic              icache_flush_o,
  input  logic              icache_ack_i,
  input  logic [31:0]       icache_rdata_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [31:0]       id_instr_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic              id_exc_req_o,
  output logic [3:0]        id_exc_code_o,
  output logic              fetch_stall_o,
  output type_fetch_state_e dbg_state_o
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned EW = XLEN + 32 + 1 + 4;

  type_fetch_state_e state_q, state_d;
  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   addr_q, addr_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            can_start, misalign, room_issue, room_exc;
  logic            exc_misalign, exc_pf, issue, ack_fire;
  logic            bypass_vld, bypass_used;
  logic            q_push, q_pop, q_empty;
  logic [EW-1:0]   q_wdata, q_rdata, resp_entry;
  logic [CW-1:0]   q_count;

  // Redirect selection, issue gating and exception detection.
  always_comb begin
    redirect     = csr_new_pc_req_i | wfi_req_i | exe_new_pc_req_i;
    redirect_pc  = (csr_new_pc_req_i | wfi_req_i) ? csr_pc_new_i : exe_pc_new_i;
    misalign     = (fpc_q[1:0] != 2'b00);
    room_issue   = (q_count + CW'(busy_q)) < CW'(QDEPTH);
    room_exc     = q_count < CW'(QDEPTH);
    can_start    = !rst && (state_q == FETCH) && !busy_q && !redirect;
    exc_misalign = can_start && misalign && room_exc;
    exc_pf       = can_start && !misalign && mmu_page_fault_i && room_exc;
    issue        = can_start && !misalign && !mmu_page_fault_i && mmu_hit_i && room_issue;
    ack_fire     = !rst && !redirect && icache_ack_i && (busy_q || issue);
    resp_entry   = {fpc_q, icache_rdata_i, 1'b0, 4'h0};
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_vld  = q_empty && ack_fire;
  assign bypass_used = bypass_vld && id_ready_i;
`else
  assign bypass_vld  = 1'b0;
  assign bypass_used = 1'b0;
`endif

  // Queue write side: exception entries or icache responses.
  always_comb begin
    q_push  = 1'b0;
    q_wdata = resp_entry;
    if (exc_misalign) begin
      q_push  = 1'b1;
      q_wdata = {fpc_q, INSTR_NOP, 1'b1, EXC_CODE_INSTR_MISALIGN};
    end else if (exc_pf) begin
      q_push  = 1'b1;
      q_wdata = {fpc_q, INSTR_NOP, 1'b1, EXC_CODE_INST_PAGE_FAULT};
    end else if (ack_fire && !bypass_used) begin
      q_push  = 1'b1;
    end
  end

  assign q_pop = !q_empty && id_ready_i;

  fetch_queue_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  // Next fetch PC, outstanding flag, latched icache address and FSM state.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    if (redirect) begin
      fpc_d   = redirect_pc;
      busy_d  = 1'b0;
      state_d = FETCH;
    end else begin
      if (issue) begin
        addr_d = mmu_paddr_i;
        busy_d = 1'b1;
      end
      if (ack_fire) begin
        fpc_d  = fpc_q + XLEN'(4);
        busy_d = 1'b0;
      end
      if (exc_misalign || exc_pf) state_d = HALT;
    end
  end

  // Fetch control registers and the two-state FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      fpc_q   <= PC_RESET;
      busy_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
    end
  end

  // ID outputs: queue head, bypassed response, or an idle NOP.
  always_comb begin
    id_valid_o    = 1'b0;
    id_instr_o    = INSTR_NOP;
    id_pc_o       = '0;
    id_exc_req_o  = 1'b0;
    id_exc_code_o = 4'h0;
    if (!q_empty) begin
      id_valid_o = 1'b1;
      {id_pc_o, id_instr_o, id_exc_req_o, id_exc_code_o} = q_rdata;
    end else if (bypass_vld) begin
      id_valid_o = 1'b1;
      {id_pc_o, id_instr_o, id_exc_req_o, id_exc_code_o} = resp_entry;
    end
  end

  assign mmu_req_o      = (state_q == FETCH);
  assign mmu_vaddr_o    = fpc_q;
  assign icache_req_o   = !rst && (busy_q || issue);
  assign icache_addr_o  = busy_q ? addr_q : mmu_paddr_i;
  assign icache_kill_o  = !rst && redirect;
  assign icache_flush_o = icache_flush_i;
  assign fetch_stall_o  = !id_valid_o;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: identity MMU and a zero-wait icache model
// whose data is address + 0x1000_0000, with ack gating controlled by the bench.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              csr_new_pc_req_i, wfi_req_i, exe_new_pc_req_i;
  logic [31:0]       csr_pc_new_i, exe_pc_new_i;
  logic              icache_flush_i;
  logic              mmu_req_o;
  logic [31:0]       mmu_vaddr_o;
  logic              mmu_hit_i;
  logic [31:0]       mmu_paddr_i;
  logic              mmu_page_fault_i;
  logic              icache_req_o;
  logic [31:0]       icache_addr_o;
  logic              icache_kill_o, icache_flush_o;
  logic              icache_ack_i;
  logic [31:0]       icache_rdata_i;
  logic              id_valid_o, id_ready_i;
  logic [31:0]       id_instr_o, id_pc_o;
  logic              id_exc_req_o;
  logic [3:0]        id_exc_code_o;
  logic              fetch_stall_o;
  type_fetch_state_e dbg_state_o;

  logic ack_en;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acks = 0;

  fetch_queue dut (
    .clk              (clk),
    .rst              (rst),
    .csr_new_pc_req_i (csr_new_pc_req_i),
    .wfi_req_i        (wfi_req_i),
    .csr_pc_new_i     (csr_pc_new_i),
    .exe_new_pc_req_i (exe_new_pc_req_i),
    .exe_pc_new_i     (exe_pc_new_i),
    .icache_flush_i   (icache_flush_i),
    .mmu_req_o        (mmu_req_o),
    .mmu_vaddr_o      (mmu_vaddr_o),
    .mmu_hit_i        (mmu_hit_i),
    .mmu_paddr_i      (mmu_paddr_i),
    .mmu_page_fault_i (mmu_page_fault_i),
    .icache_req_o     (icache_req_o),
    .icache_addr_o    (icache_addr_o),
    .icache_kill_o    (icache_kill_o),
    .icache_flush_o   (icache_flush_o),
    .icache_ack_i     (icache_ack_i),
    .icache_rdata_i   (icache_rdata_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .id_exc_req_o     (id_exc_req_o),
    .id_exc_code_o    (id_exc_code_o),
    .fetch_stall_o    (fetch_stall_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock and environment models.
  always #5 clk = ~clk;

  assign mmu_paddr_i    = mmu_vaddr_o;
  assign icache_ack_i   = ack_en & icache_req_o;
  assign icache_rdata_i = icache_addr_o + 32'h1000_0000;

  // Count accepted icache transactions (pushes from the icache side).
  always @(posedge clk) begin
    if (!rst && icache_req_o && icache_ack_i && !icache_kill_o) n_acks <= n_acks + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_exe(input logic [31:0] tgt);
    exe_new_pc_req_i = 1'b1;
    exe_pc_new_i     = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    csr_new_pc_req_i = 1'b0; wfi_req_i = 1'b0; exe_new_pc_req_i = 1'b0;
    csr_pc_new_i = '0; exe_pc_new_i = '0; icache_flush_i = 1'b0;
    mmu_hit_i = 1'b1; mmu_page_fault_i = 1'b0;
    id_ready_i = 1'b1; ack_en = 1'b1;

    // Reset values.
    tick(); tick();
    check_eq("rst_valid", id_valid_o, 0);
    check_eq("rst_instr", id_instr_o, 32'h0000_0013);
    check_eq("rst_pc", id_pc_o, 0);
    check_eq("rst_exc", {id_exc_req_o, id_exc_code_o}, 0);
    check_eq("rst_req", icache_req_o, 0);
    check_eq("rst_kill", icache_kill_o, 0);
    check_eq("rst_stall", fetch_stall_o, 1);
    check_eq("rst_fpc", mmu_vaddr_o, 32'h8000_0000);
    check_eq("rst_state", dbg_state_o, FETCH);

    // Streaming with a zero-wait icache.
    rst = 1'b0;
    #1;
    check_eq("first_issue", icache_req_o, 1);
    check_eq("first_addr", icache_addr_o, 32'h8000_0000);
`ifndef FETCH_QUEUE_BYPASS_EN
    tick();
`endif
    check_eq("stream_pc0", id_pc_o, 32'h8000_0000);
    check_eq("stream_in0", id_instr_o, 32'h9000_0000);
    tick();
    check_eq("stream_pc1", id_pc_o, 32'h8000_0004);
    tick();
    check_eq("stream_pc2", id_pc_o, 32'h8000_0008);
    check_eq("stream_in2", id_instr_o, 32'h9000_0008);

    // Back-pressure: queue fills to QDEPTH and stops requesting.
    redirect_exe(32'h8000_0200);
    id_ready_i = 1'b0;
    #1;
    check_eq("bp_kill", icache_kill_o, 1);
    n_acks = 0;
    tick();
    exe_new_pc_req_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("bp_pushes", n_acks, 4);
    check_eq("bp_req_low", icache_req_o, 0);
    check_eq("bp_valid", id_valid_o, 1);
    id_ready_i = 1'b1;
    check_eq("drain_pc0", id_pc_o, 32'h8000_0200);
    check_eq("drain_in0", id_instr_o, 32'h9000_0200);
    tick(); check_eq("drain_pc1", id_pc_o, 32'h8000_0204);
    tick(); check_eq("drain_pc2", id_pc_o, 32'h8000_0208);
    tick(); check_eq("drain_pc3", id_pc_o, 32'h8000_020C);
    tick(); check_eq("drain_pc4", id_pc_o, 32'h8000_0210);

    // Redirect coincident with an ack: the ack is dropped.
    redirect_exe(32'h8000_0300);
    ack_en = 1'b0;
    tick();
    exe_new_pc_req_i = 1'b0;
    #1;
    check_eq("hold_req", icache_req_o, 1);
    check_eq("hold_addr0", icache_addr_o, 32'h8000_0300);
    tick();
    check_eq("hold_addr1", icache_addr_o, 32'h8000_0300);
    check_eq("hold_valid", id_valid_o, 0);
    redirect_exe(32'h8000_0100);
    ack_en = 1'b1;
    #1;
    check_eq("redir_kill", icache_kill_o, 1);
    check_eq("redir_nobyp", id_valid_o, 0);
    tick();
    exe_new_pc_req_i = 1'b0;
    ack_en = 1'b0;
    #1;
    check_eq("redir_empty", id_valid_o, 0);
    check_eq("redir_nokill", icache_kill_o, 0);
    check_eq("redir_addr", icache_addr_o, 32'h8000_0100);
    check_eq("redir_req", icache_req_o, 1);

    // CSR wins over EXE when both redirect.
    csr_new_pc_req_i = 1'b1; csr_pc_new_i = 32'h8000_0400;
    redirect_exe(32'h8000_0500);
    ack_en = 1'b1;
    tick();
    csr_new_pc_req_i = 1'b0; exe_new_pc_req_i = 1'b0;
    #1;
    check_eq("prio_fpc", mmu_vaddr_o, 32'h8000_0400);
    check_eq("prio_addr", icache_addr_o, 32'h8000_0400);

    // Misaligned target: one exception entry, no request, HALT.
    redirect_exe(32'h8000_0102);
    id_ready_i = 1'b0;
    tick();
    exe_new_pc_req_i = 1'b0;
    #1;
    check_eq("mis_noreq", icache_req_o, 0);
    tick();
    check_eq("mis_state", dbg_state_o, HALT);
    check_eq("mis_valid", id_valid_o, 1);
    check_eq("mis_exc", {id_exc_req_o, id_exc_code_o}, 5'h10);
    check_eq("mis_pc", id_pc_o, 32'h8000_0102);
    check_eq("mis_instr", id_instr_o, 32'h0000_0013);
    check_eq("mis_mmureq", mmu_req_o, 0);
    tick(); tick(); tick();
    check_eq("halt_noreq", icache_req_o, 0);
    check_eq("halt_state", dbg_state_o, HALT);
    id_ready_i = 1'b1;
    tick();
    check_eq("halt_popped", id_valid_o, 0);
    check_eq("halt_stall", fetch_stall_o, 1);

    // Instruction page fault.
    redirect_exe(32'h8000_0040);
    mmu_page_fault_i = 1'b1;
    id_ready_i = 1'b0;
    tick();
    exe_new_pc_req_i = 1'b0;
    #1;
    check_eq("pf_state_fetch", dbg_state_o, FETCH);
    check_eq("pf_noreq", icache_req_o, 0);
    tick();
    mmu_page_fault_i = 1'b0;
    check_eq("pf_valid", id_valid_o, 1);
    check_eq("pf_exc", {id_exc_req_o, id_exc_code_o}, 5'h1C);
    check_eq("pf_pc", id_pc_o, 32'h8000_0040);
    check_eq("pf_instr", id_instr_o, 32'h0000_0013);
    check_eq("pf_state", dbg_state_o, HALT);

    // Reset in the middle of an outstanding fetch.
    redirect_exe(32'h8000_0600);
    id_ready_i = 1'b1;
    ack_en = 1'b0;
    tick();
    exe_new_pc_req_i = 1'b0;
    #1;
    check_eq("mrst_addr", icache_addr_o, 32'h8000_0600);
    tick();
    rst = 1'b1;
    ack_en = 1'b1;
    tick();
    rst = 1'b0;
    ack_en = 1'b0;
    #1;
    check_eq("mrst_valid", id_valid_o, 0);
    check_eq("mrst_fpc", mmu_vaddr_o, 32'h8000_0000);
    check_eq("mrst_req", icache_req_o, 1);
    check_eq("mrst_raddr", icache_addr_o, 32'h8000_0000);
    check_eq("flush_pass", icache_flush_o, 0);
    icache_flush_i = 1'b1;
    #1;
    check_eq("flush_pass1", icache_flush_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor of the single-entry fetch stage: a fetch unit that decouples instruction fetch from decode through a QDEPTH-entry instruction queue. It generates fetch PCs, translates them through the MMU, issues requests to the instruction cache, and buffers returned instructions, or fetch exceptions, for the ID stage. On a redirect from CSR or EXE it flushes the queue and any in-flight fetch. It sits between the MMU/icache and the ID pipeline register.

## Interface
- XLEN, 32, address/data width
- QDEPTH, 4, queue entries; power of two, ≥2
- PC_RESET, 32'h8000_0000, fetch PC after reset
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- csr_new_pc_req_i  in  1  CSR redirect (highest priority)
- wfi_req_i  in  1  WFI redirect; target is csr_pc_new_i
- csr_pc_new_i  in  XLEN  CSR/WFI target
- exe_new_pc_req_i  in  1  branch/jump redirect (lowest priority)
- exe_pc_new_i  in  XLEN  EXE target
- icache_flush_i  in  1  fence.i flush request from CSR
- mmu_req_o  out  1  translation request
- mmu_vaddr_o  out  XLEN  fetch virtual address
- mmu_hit_i  in  1  translation valid
- mmu_paddr_i  in  XLEN  physical address
- mmu_page_fault_i  in  1  instruction page fault
- icache_req_o  out  1  fetch request
- icache_addr_o  out  XLEN  physical fetch address
- icache_kill_o  out  1  drop in-flight request
- icache_flush_o  out  1  equals icache_flush_i
- icache_ack_i  in  1  response valid
- icache_rdata_i  in  32  instruction
- id_valid_o  out  1  queue head valid
- id_ready_i  in  1  ID consumes head
- id_instr_o  out  32  head instruction; NOP (32'h0000_0013) when invalid
- id_pc_o  out  XLEN  head PC
- id_exc_req_o  out  1  head carries fetch exception
- id_exc_code_o  out  4  exception code: 0 instr misaligned, 12 page fault
- fetch_stall_o  out  1  asserted when ~id_valid_o; goes to the forward/stall unit

## Operation
- The FSM has two states. FETCH issues requests. HALT is entered after an exception entry has been queued and is left only on a redirect.
- The fetch PC register fpc drives mmu_vaddr_o. mmu_req_o is 1 in FETCH.
- At most one request is outstanding. The flag `busy` is set on issue and cleared on ack or kill.
- Issue condition: FETCH, ~busy, mmu_hit_i, count + busy < QDEPTH, no redirect.
- When issued, icache_req_o is held with a stable icache_addr_o until icache_ack_i.
- On ack, the queue pushes {fpc, icache_rdata_i, exc=0}, and fpc advances by 4.
- If fpc[1:0] ≠ 0, the queue pushes {fpc, NOP, exc=1, code 0} without any icache request, and the FSM goes to HALT.
- If mmu_page_fault_i occurs with no outstanding request, the queue pushes {fpc, NOP, exc=1, code 12}, and the FSM goes to HALT. Misalignment has priority over page fault.
- Pop happens on id_valid_o & id_ready_i. Push and pop may occur in the same cycle, including when the queue is full, because the issue gating reserves the slot.
- Redirect priority is csr > wfi > exe. On a redirect:
  - fpc takes the target;
  - the queue is emptied (count=0, pointers=0);
  - busy is cleared and the FSM goes to FETCH;
  - icache_kill_o=1 for that cycle;
  - an icache_ack_i arriving in the redirect cycle is discarded.
- count is $clog2(QDEPTH)+1 bits wide. Read and write pointers are $clog2(QDEPTH) bits wide and wrap naturally.

## Timing
- Reset (cycle after rst=1) values:
  - fpc=PC_RESET, count=0, busy=0, FSM=FETCH;
  - id_valid_o=0, id_instr_o=NOP, id_pc_o=0, id_exc_req_o=0, id_exc_code_o=0;
  - icache_req_o=0, icache_kill_o=0, fetch_stall_o=1.
- A reset applied mid-fetch abandons the outstanding request, and no push occurs.
- Latency: ack in cycle N gives id_valid_o in cycle N+1. The earliest issue is the first cycle after reset release.
- Throughput is one instruction per cycle when the icache acks in the issue cycle.
- Redirect in cycle N: the first request to the target can issue in cycle N+1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when the queue is empty and icache_ack_i is valid, the response is driven to the ID outputs combinationally in cycle N.
  - If id_ready_i is 1 in that cycle, the entry is not pushed.
  - A redirect in the same cycle suppresses the bypass.
- Undefined: every instruction passes through the queue, and latency is 1 cycle.

## Structure
- The shared package (pcore fetch package) holds:
  - typedef type_ifq_entry_s {pc, instr, exc_req, exc_code};
  - enum type_fetch_state_e {FETCH, HALT};
  - constants INSTR_NOP, EXC_CODE_INSTR_MISALIGN, EXC_CODE_INST_PAGE_FAULT.
- Sub-module fetch_queue_fifo is the parametrised synchronous FIFO with a flush input. It is instantiated once.

## Test plan
- Reset, then zero-wait-state icache with id_ready_i=1: ID sees PCs 0x8000_0000, …_0004, …_0008 on consecutive cycles starting at cycle 2 (cycle 1 with bypass).
- id_ready_i=0 for 10 cycles with QDEPTH=4: exactly 4 pushes, and icache_req_o stays low afterwards. When id_ready_i returns to 1, entries drain in order.
- exe_new_pc_req_i with target 0x8000_0100 in the same cycle as an ack: the ack is discarded, the queue is empty, icache_kill_o pulses, and the next request address is 0x8000_0100.
- csr_new_pc_req_i and exe_new_pc_req_i asserted together: fpc takes csr_pc_new_i.
- exe target 0x8000_0102: one entry with exc=1 and code 0, no icache request, HALT until the next redirect.
- mmu_page_fault_i at fpc 0x8000_0040: entry exc=1, code 12, id_instr_o=NOP.
